digital_clock_param: RTL and testbench

- Parametrised time-of-day counter (hh:mm:ss), successor to the fixed 100 MHz / 24 h clock block.
- A single-clock-domain prescaler produces a one-cycle second enable, so the block has no derived clock.
- Adds run/hold, validated time load, a 12/24 h display mode, an hh:mm alarm, and tick/day-wrap status pulses.
- Sits between the board clock and the display/alarm logic.

---
 rtl/digital_clock_param.sv | 172 +++++++++++++++++
 tb/tb_digital_clock_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_param.sv
// Parametrised hh:mm:ss time-of-day counter driven by a one-cycle second enable
// from an in-domain prescaler, with validated load, 12/24 h display, alarm and status pulses.
module digital_clock_param #(
  parameter int CYCLES_PER_SEC = 100000000,
  parameter int PRESC_W        = $clog2(CYCLES_PER_SEC)
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);

  logic [PRESC_W-1:0] r_presc;
  logic [5:0]         r_sec;
  logic [5:0]         r_min;
  logic [4:0]         r_hour;
  logic               r_tick;
  logic               r_wrap;
  logic               r_alarm;
  logic               r_lerr;

  logic [PRESC_W-1:0] w_presc_nxt;
  logic [5:0]         w_sec_nxt;
  logic [5:0]         w_min_nxt;
  logic [4:0]         w_hour_nxt;
  logic               w_tick_nxt;
  logic               w_wrap_nxt;
  logic               w_alarm_nxt;
  logic               w_lerr_nxt;

  logic [5:0]         w_sec_inc;
  logic [5:0]         w_min_inc;
  logic [4:0]         w_hour_inc;
  logic               w_wrap_inc;
  logic               w_alarm_match;
  logic               w_load_ok;
  logic               w_adv;

  assign w_load_ok = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign w_adv     = run && (r_presc == PRESC_LAST);

  // Time value one second after the current one, with sexagesimal/day carries.
  always_comb begin
    w_sec_inc  = r_sec;
    w_min_inc  = r_min;
    w_hour_inc = r_hour;
    if (r_sec == 6'd59) begin
      w_sec_inc = 6'd0;
      if (r_min == 6'd59) begin
        w_min_inc = 6'd0;
        if (r_hour == 5'd23) begin
          w_hour_inc = 5'd0;
        end else begin
          w_hour_inc = r_hour + 5'd1;
        end
      end else begin
        w_min_inc = r_min + 6'd1;
      end
    end else begin
      w_sec_inc = r_sec + 6'd1;
    end
  end

  assign w_wrap_inc    = (r_sec == 6'd59) && (r_min == 6'd59) && (r_hour == 5'd23);
  // Out-of-range alarm fields can never equal a legal incremented time.
  assign w_alarm_match = alarm_en && (w_hour_inc == alarm_hour) &&
                         (w_min_inc == alarm_min) && (w_sec_inc == 6'd0);

  // Next-state selection: a valid load outranks a same-cycle advance.
  always_comb begin
    w_presc_nxt = r_presc;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_alarm_nxt = 1'b0;
    w_lerr_nxt  = load && !w_load_ok;
    if (load && w_load_ok) begin
      w_presc_nxt = PRESC_ZERO;
      w_sec_nxt   = load_sec;
      w_min_nxt   = load_min;
      w_hour_nxt  = load_hour;
    end else if (w_adv) begin
      w_presc_nxt = PRESC_ZERO;
      w_sec_nxt   = w_sec_inc;
      w_min_nxt   = w_min_inc;
      w_hour_nxt  = w_hour_inc;
      w_tick_nxt  = 1'b1;
      w_wrap_nxt  = w_wrap_inc;
      w_alarm_nxt = w_alarm_match;
    end else if (run) begin
      w_presc_nxt = r_presc + PRESC_ONE;
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // State and status-pulse registers.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= PRESC_ZERO;
      r_sec   <= 6'd0;
      r_min   <= 6'd0;
      r_hour  <= 5'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_alarm <= 1'b0;
      r_lerr  <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_sec   <= w_sec_nxt;
      r_min   <= w_min_nxt;
      r_hour  <= w_hour_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
      r_alarm <= w_alarm_nxt;
      r_lerr  <= w_lerr_nxt;
    end
  end

  assign second    = r_sec;
  assign minute    = r_min;
  assign hour      = r_hour;
  assign sec_tick  = r_tick;
  assign day_wrap  = r_wrap;
  assign alarm_hit = r_alarm;
  assign load_err  = r_lerr;

  // Display hour: 24 h passthrough or 12 h with midnight/noon shown as 12.
  always_comb begin
    hour_disp = r_hour;
    pm        = 1'b0;
    if (!mode_12h) begin
      hour_disp = r_hour;
      pm        = 1'b0;
    end else if (r_hour == 5'd0) begin
      hour_disp = 5'd12;
      pm        = 1'b0;
    end else if (r_hour < 5'd12) begin
      hour_disp = r_hour;
      pm        = 1'b0;
    end else if (r_hour == 5'd12) begin
      hour_disp = 5'd12;
      pm        = 1'b1;
    end else begin
      hour_disp = r_hour - 5'd12;
      pm        = 1'b1;
    end
  end

endmodule

// File: tb/tb_digital_clock_param.sv
// Self-checking bench: seconds-of-day reference model compared every cycle, plus
// a display/load vector table and directed corner-case sequences.
module tb_digital_clock_param;

  localparam int CPS = 4;

  logic       clk_100 = 1'b0;
  logic       rst_n, run, mode_12h, load, alarm_en;
  logic [4:0] load_hour, alarm_hour;
  logic [5:0] load_min, load_sec, alarm_min;
  logic [5:0] second, minute;
  logic [4:0] hour, hour_disp;
  logic       pm, sec_tick, day_wrap, alarm_hit, load_err;

  digital_clock_param #(.CYCLES_PER_SEC(CPS)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .run(run), .mode_12h(mode_12h),
    .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .second(second), .minute(minute), .hour(hour), .hour_disp(hour_disp), .pm(pm),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .alarm_hit(alarm_hit), .load_err(load_err)
  );

  always #5 clk_100 = ~clk_100;

  int   errors = 0;
  int   checks = 0;
  int   m_tod, m_cnt;
  logic e_tick, e_wrap, e_alarm, e_err;

  typedef struct {
    logic       mode;
    logic [4:0] lh;
    logic [5:0] lm;
    logic [5:0] ls;
    logic [4:0] hr;
    logic [4:0] disp;
    logic       pm;
    logic       err;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] pack_dut();
    return {second, minute, hour, hour_disp, pm, sec_tick, day_wrap, alarm_hit, load_err};
  endfunction

  function automatic logic [26:0] pack_exp();
    int   h, d;
    logic p;
    h = m_tod / 3600;
    if (!mode_12h) begin
      d = h; p = 1'b0;
    end else begin
      d = (h % 12 == 0) ? 12 : h % 12;
      p = (h >= 12);
    end
    return {6'(m_tod % 60), 6'((m_tod / 60) % 60), 5'(h), 5'(d), p,
            e_tick, e_wrap, e_alarm, e_err};
  endfunction

  task automatic model_reset();
    m_tod = 0; m_cnt = 0;
    e_tick = 1'b0; e_wrap = 1'b0; e_alarm = 1'b0; e_err = 1'b0;
  endtask

  // Reference: time as seconds since midnight, prescaler as a cycle counter.
  task automatic model_edge();
    logic valid;
    if (!rst_n) begin
      model_reset();
    end else begin
      valid  = (int'(load_hour) < 24) && (int'(load_min) < 60) && (int'(load_sec) < 60);
      e_tick = 1'b0; e_wrap = 1'b0; e_alarm = 1'b0;
      e_err  = load && !valid;
      if (load && valid) begin
        m_tod = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
        m_cnt = 0;
      end else if (run) begin
        if (m_cnt == CPS - 1) begin
          m_cnt   = 0;
          m_tod   = (m_tod + 1) % 86400;
          e_tick  = 1'b1;
          e_wrap  = (m_tod == 0);
          e_alarm = alarm_en && (int'(alarm_hour) < 24) && (int'(alarm_min) < 60) &&
                    (m_tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_100);
    #1;
    check("cycle", 32'(pack_dut()), 32'(pack_exp()));
  endtask

  task automatic set_load(input int t);
    load      = 1'b1;
    load_hour = 5'(t / 3600);
    load_min  = 6'((t / 60) % 60);
    load_sec  = 6'(t % 60);
  endtask

  initial begin
    logic [26:0] rst12;
    int t;
    vt[0]  = '{1'b1, 5'd0,  6'd0,  6'd0,  5'd0,  5'd12, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd11, 6'd5,  6'd6,  5'd11, 5'd11, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd12, 6'd0,  6'd0,  5'd12, 5'd12, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 5'd13, 6'd0,  6'd0,  5'd13, 5'd1,  1'b1, 1'b0};
    vt[4]  = '{1'b1, 5'd23, 6'd0,  6'd0,  5'd23, 5'd11, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 5'd13, 6'd0,  6'd0,  5'd13, 5'd13, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd24, 6'd0,  6'd0,  5'd13, 5'd13, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 5'd10, 6'd60, 6'd0,  5'd13, 5'd1,  1'b1, 1'b1};
    vt[8]  = '{1'b1, 5'd10, 6'd0,  6'd60, 5'd13, 5'd1,  1'b1, 1'b1};
    vt[9]  = '{1'b0, 5'd0,  6'd0,  6'd0,  5'd0,  5'd0,  1'b0, 1'b0};
    vt[10] = '{1'b1, 5'd31, 6'd63, 6'd63, 5'd0,  5'd12, 1'b0, 1'b1};

    rst_n = 1'b0; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
    load_hour = 5'd0; load_min = 6'd0; load_sec = 6'd0;
    alarm_en = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;
    model_reset();
    repeat (2) @(posedge clk_100);
    #1;
    check("reset_state", 32'(pack_dut()), 32'd0);

    // Free-running count.
    rst_n = 1'b1; run = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (i == 4)  check("tick1", {sec_tick, second}, {1'b1, 6'd1});
      if (i == 8)  check("tick2", {sec_tick, second}, {1'b1, 6'd2});
      if (i == 12) check("tick3", {sec_tick, second}, {1'b1, 6'd3});
    end
    check("min_roll", {minute, second}, {6'd1, 6'd0});

    // Load near midnight and roll over the day.
    set_load(23 * 3600 + 59 * 60 + 58); step(); load = 1'b0;
    check("load_val", {hour, minute, second, load_err}, {5'd23, 6'd59, 6'd58, 1'b0});
    repeat (4) step();
    check("sec59", {second, sec_tick}, {6'd59, 1'b1});
    repeat (4) step();
    check("day_wrap", {hour, minute, second, sec_tick, day_wrap}, {5'd0, 6'd0, 6'd0, 1'b1, 1'b1});

    // Invalid loads, and loads coinciding with the advance cycle.
    load = 1'b1; load_hour = 5'd24; load_min = 6'd0; load_sec = 6'd0; step();
    check("err_hour", {load_err, hour, second}, {1'b1, 5'd0, 6'd0});
    load_hour = 5'd10; load_min = 6'd60; step();
    check("err_min", {load_err, hour, minute}, {1'b1, 5'd0, 6'd0});
    load = 1'b0; step();
    set_load(5 * 3600 + 6 * 60 + 7); step(); load = 1'b0;
    check("load_wins", {hour, minute, second, sec_tick}, {5'd5, 6'd6, 6'd7, 1'b0});
    repeat (3) step();
    load = 1'b1; load_hour = 5'd24; step(); load = 1'b0;
    check("bad_load_adv", {second, sec_tick, load_err}, {6'd8, 1'b1, 1'b1});

    // Alarm.
    alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    set_load(7 * 3600 + 29 * 60 + 59); step(); load = 1'b0;
    repeat (4) step();
    check("alarm_hit", {alarm_hit, sec_tick, hour, minute, second}, {1'b1, 1'b1, 5'd7, 6'd30, 6'd0});
    step();
    check("alarm_1cyc", {1'b0, alarm_hit}, 2'b00);
    set_load(7 * 3600 + 30 * 60); step(); load = 1'b0;
    check("alarm_on_load", {alarm_hit, minute}, {1'b0, 6'd30});
    alarm_en = 1'b0;
    set_load(7 * 3600 + 29 * 60 + 59); step(); load = 1'b0;
    repeat (4) step();
    check("alarm_dis", {alarm_hit, sec_tick, minute}, {1'b0, 1'b1, 6'd30});

    // Display/load vector table, clock held.
    run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mode_12h = vt[i].mode; load = 1'b1;
      load_hour = vt[i].lh; load_min = vt[i].lm; load_sec = vt[i].ls;
      step(); load = 1'b0;
      check("tbl_hour", {27'd0, hour}, {27'd0, vt[i].hr});
      check("tbl_disp", {hour_disp, pm, load_err}, {vt[i].disp, vt[i].pm, vt[i].err});
    end
    mode_12h = 1'b0;

    // Run hold mid-count preserves the remaining prescaler cycles.
    run = 1'b1;
    set_load(1 * 3600 + 2 * 60 + 3); step(); load = 1'b0;
    repeat (2) step();
    run = 1'b0;
    repeat (10) step();
    check("hold", {second, sec_tick}, {6'd3, 1'b0});
    run = 1'b1; step();
    check("resume_wait", {second, sec_tick}, {6'd3, 1'b0});
    step();
    check("resume_tick", {second, sec_tick}, {6'd4, 1'b1});

    // Randomized traffic against the model.
    alarm_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        alarm_hour = 5'($urandom_range(0, 24));
        alarm_min  = 6'($urandom_range(0, 61));
        alarm_en   = 1'($urandom_range(0, 3) != 0);
      end
      run      = ($urandom_range(0, 7) != 0);
      mode_12h = 1'($urandom_range(0, 1));
      t        = int'($urandom_range(0, 63));
      if (t < 3) begin
        load = 1'b1;
        load_hour = 5'($urandom_range(0, 25));
        load_min  = 6'($urandom_range(0, 61));
        load_sec  = 6'($urandom_range(0, 61));
      end else if (t < 5) begin
        set_load((int'(alarm_hour) * 3600 + int'(alarm_min) * 60 -
                  int'($urandom_range(1, 3)) + 86400) % 86400);
      end else if (t == 5) begin
        set_load(86400 - int'($urandom_range(1, 3)));
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0; run = 1'b1;

    // Asynchronous reset mid-cycle.
    mode_12h = 1'b1;
    set_load(15 * 3600 + 45 * 60 + 30); step(); load = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    rst12 = {6'd0, 6'd0, 5'd0, 5'd12, 5'd0};
    check("async_reset", 32'(pack_dut()), 32'(rst12));
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
